// File: rtl/vc_gp_fifo_pkg.sv
// rtl/vc_gp_fifo_pkg.sv - shared helpers, occupancy type macro and elaboration checks for the VC FIFO
`ifndef GP_FIFO_PKG_MACROS
`define GP_FIFO_PKG_MACROS
`define GP_FIFO_OCC_T(slots) logic [$clog2(slots):0]
`define GP_FIFO_ELAB_ASSERT(name, cond, msg) if (!(cond)) begin : name $error(msg); end
`endif

package gp_fifo_pkg;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int occ_width(input int slots);
    return $clog2(slots) + 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/vc_gp_fifo_if.sv
// rtl/vc_gp_fifo_if.sv - shared write/read/flag bundle between a client and the VC FIFO
interface vc_gp_fifo_if #(
  parameter int VC_NUM = 2,
  parameter int WIDTH  = 8,
  parameter int VC_W   = 1,
  parameter int OCC_W  = 3
);
  logic                    wr_en_i;
  logic [VC_W-1:0]         wr_vc_i;
  logic [WIDTH-1:0]        wr_data_i;
  logic                    rd_en_i;
  logic [VC_W-1:0]         rd_vc_i;
  logic [WIDTH-1:0]        rd_data_o;
  logic [VC_NUM-1:0]       wr_full_o;
  logic [VC_NUM-1:0]       wr_afull_o;
  logic [VC_NUM-1:0]       rd_empty_o;
  logic [VC_NUM*OCC_W-1:0] occ_o;
  logic                    err_clr_i;
  logic [VC_NUM-1:0]       err_ovf_o;
  logic [VC_NUM-1:0]       err_udf_o;

  modport master (
    output wr_en_i, wr_vc_i, wr_data_i, rd_en_i, rd_vc_i, err_clr_i,
    input  rd_data_o, wr_full_o, wr_afull_o, rd_empty_o, occ_o, err_ovf_o, err_udf_o
  );

  modport slave (
    input  wr_en_i, wr_vc_i, wr_data_i, rd_en_i, rd_vc_i, err_clr_i,
    output rd_data_o, wr_full_o, wr_afull_o, rd_empty_o, occ_o, err_ovf_o, err_udf_o
  );
endinterface

// File: rtl/vc_gp_fifo_ch.sv
// rtl/vc_gp_fifo_ch.sv - one virtual-channel queue: wrap-bit pointers, storage, flags, occupancy
module sync_gp_fifo_ch
  import gp_fifo_pkg::*;
#(
  parameter int SLOTS    = 4,
  parameter int WIDTH    = 8,
  parameter int AFULL_TH = SLOTS - 1
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     head_data,
  output logic                 full,
  output logic                 afull,
  output logic                 empty,
  output `GP_FIFO_OCC_T(SLOTS) occ
);
  localparam int IDX_W = $clog2(SLOTS);
  localparam int OCC_W = occ_width(SLOTS);

  `GP_FIFO_OCC_T(SLOTS) wr_ptr;
  `GP_FIFO_OCC_T(SLOTS) rd_ptr;
  logic [WIDTH-1:0]     mem [SLOTS];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + OCC_W'(1);
      if (pop)  rd_ptr <= rd_ptr + OCC_W'(1);
    end
  end

  // Storage is deliberately left unreset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IDX_W-1:0]] <= push_data;
  end

  assign head_data = mem[rd_ptr[IDX_W-1:0]];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                     (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign occ       = wr_ptr - rd_ptr;
  assign afull     = (occ >= OCC_W'(AFULL_TH));
endmodule

// File: rtl/vc_gp_fifo.sv
// rtl/vc_gp_fifo.sv - single-clock multi-VC FIFO: channel steering, pass-through on full, read mux, sticky errors
module vc_gp_fifo
  import gp_fifo_pkg::*;
#(
  parameter int VC_NUM   = 2,
  parameter int SLOTS    = 4,
  parameter int WIDTH    = 8,
  parameter int AFULL_TH = SLOTS - 1
) (
  input logic         clk,
  input logic         arst_n,
  vc_gp_fifo_if.slave bus
);
  localparam int VC_W  = clog2_min1(VC_NUM);
  localparam int OCC_W = occ_width(SLOTS);

  `GP_FIFO_ELAB_ASSERT(g_chk_slots, is_pow2(SLOTS) && (SLOTS >= 2), "SLOTS must be a power of 2 and >= 2")
  `GP_FIFO_ELAB_ASSERT(g_chk_vc, VC_NUM >= 1, "VC_NUM must be >= 1")
  `GP_FIFO_ELAB_ASSERT(g_chk_afull, (AFULL_TH >= 1) && (AFULL_TH <= SLOTS), "AFULL_TH must be in 1..SLOTS")

  logic [VC_NUM-1:0] push;
  logic [VC_NUM-1:0] pop;
  logic [VC_NUM-1:0] wr_hit;
  logic [VC_NUM-1:0] rd_hit;
  logic [VC_NUM-1:0] full;
  logic [VC_NUM-1:0] afull;
  logic [VC_NUM-1:0] empty;
  logic [VC_NUM-1:0] ovf_set;
  logic [VC_NUM-1:0] udf_set;
  logic [VC_NUM-1:0] err_ovf;
  logic [VC_NUM-1:0] err_udf;
  logic [WIDTH-1:0]  head [VC_NUM];

  // Out-of-range channel indices match no lane, so they are silently ignored.
  for (genvar v = 0; v < VC_NUM; v++) begin : g_ch
    assign wr_hit[v]  = bus.wr_en_i && (bus.wr_vc_i == VC_W'(v));
    assign rd_hit[v]  = bus.rd_en_i && (bus.rd_vc_i == VC_W'(v));
    assign pop[v]     = rd_hit[v] && !empty[v];
    assign push[v]    = wr_hit[v] && (!full[v] || pop[v]);
    assign ovf_set[v] = wr_hit[v] && full[v] && !pop[v];
    assign udf_set[v] = rd_hit[v] && empty[v];

    sync_gp_fifo_ch #(
      .SLOTS    (SLOTS),
      .WIDTH    (WIDTH),
      .AFULL_TH (AFULL_TH)
    ) u_ch (
      .clk       (clk),
      .arst_n    (arst_n),
      .push      (push[v]),
      .push_data (bus.wr_data_i),
      .pop       (pop[v]),
      .head_data (head[v]),
      .full      (full[v]),
      .afull     (afull[v]),
      .empty     (empty[v]),
      .occ       (bus.occ_o[v*OCC_W +: OCC_W])
    );
  end

  always_comb begin
    bus.rd_data_o = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (bus.rd_vc_i == VC_W'(v)) bus.rd_data_o = head[v];
    end
  end

  // A new error event outranks a clear arriving in the same cycle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      err_ovf <= '0;
      err_udf <= '0;
    end else begin
      err_ovf <= (err_ovf & ~{VC_NUM{bus.err_clr_i}}) | ovf_set;
      err_udf <= (err_udf & ~{VC_NUM{bus.err_clr_i}}) | udf_set;
    end
  end

  assign bus.wr_full_o  = full;
  assign bus.wr_afull_o = afull;
  assign bus.rd_empty_o = empty;
  assign bus.err_ovf_o  = err_ovf;
  assign bus.err_udf_o  = err_udf;
endmodule
